// File: rtl/pattern_busy_sequencer.sv
// Two-pass scheduler for the best-1-of-5 zone sorter in the ccLUT pattern finder.
// Pass 1 captures the first CLCT. Pass 2 marks busy every zone whose candidate
// key lies within BSY_HW of the first CLCT's key, then captures the second CLCT.
//
// Ports:
//   clock, reset_n            system clock, asynchronous active-low reset
//   start                     one-cycle run request, ignored unless idle
//   bsy_ext, zone_vld         forced busy mask / candidate-present mask, latched at start
//   zone_key0..zone_key4      per-zone candidate full keys, latched at start
//   best_pat/key/subkey/bsy   sorter result
//   sort_bsy                  registered busy mask driven to the sorter
//   seq_busy                  sequencer not idle
//   clct1_*, clct2_*          first and second CLCT
//   done                      one-cycle pulse, clct outputs final
module pattern_busy_sequencer #(
  parameter int unsigned PATB     = 6,
  parameter int unsigned KEYB     = 8,
  parameter int unsigned SUBKEYB  = 10,
  parameter int unsigned SORT_LAT = 1,
  parameter int unsigned BSY_HW   = 7
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [4:0]         bsy_ext,
  input  logic [4:0]         zone_vld,
  input  logic [KEYB-1:0]    zone_key0,
  input  logic [KEYB-1:0]    zone_key1,
  input  logic [KEYB-1:0]    zone_key2,
  input  logic [KEYB-1:0]    zone_key3,
  input  logic [KEYB-1:0]    zone_key4,
  input  logic [PATB-1:0]    best_pat,
  input  logic [KEYB-1:0]    best_key,
  input  logic [SUBKEYB-1:0] best_subkey,
  input  logic               best_bsy,
  output logic [4:0]         sort_bsy,
  output logic               seq_busy,
  output logic               clct1_vld,
  output logic [PATB-1:0]    clct1_pat,
  output logic [KEYB-1:0]    clct1_key,
  output logic [SUBKEYB-1:0] clct1_subkey,
  output logic               clct2_vld,
  output logic [PATB-1:0]    clct2_pat,
  output logic [KEYB-1:0]    clct2_key,
  output logic [SUBKEYB-1:0] clct2_subkey,
  output logic               done
);

  typedef enum logic [1:0] {StIdle, StPass1, StPass2} state_e;

  localparam logic [2:0]    CntInit = 3'(SORT_LAT - 1);
  localparam logic [KEYB:0] BsyHw   = (KEYB + 1)'(BSY_HW);

  state_e                  state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [4:0]              sort_bsy_q, sort_bsy_d;
  logic [4:0]              bsy_ext_l_q, bsy_ext_l_d;
  logic [4:0]              zone_vld_l_q, zone_vld_l_d;
  logic [4:0][KEYB-1:0]    zone_key_l_q, zone_key_l_d;
  logic [4:0][KEYB-1:0]    zone_key_in;
  logic                    clct1_vld_q, clct1_vld_d, clct2_vld_q, clct2_vld_d;
  logic [PATB-1:0]         clct1_pat_q, clct1_pat_d, clct2_pat_q, clct2_pat_d;
  logic [KEYB-1:0]         clct1_key_q, clct1_key_d, clct2_key_q, clct2_key_d;
  logic [SUBKEYB-1:0]      clct1_sub_q, clct1_sub_d, clct2_sub_q, clct2_sub_d;
  logic                    done_q, done_d;
  logic [KEYB:0]           key_diff [5];
  logic [KEYB:0]           key_mag  [5];
  logic [4:0]              near_mask;
  logic                    cap_vld;

  assign zone_key_in = {zone_key4, zone_key3, zone_key2, zone_key1, zone_key0};
  assign cap_vld     = (best_pat != '0) && !best_bsy;

  // Zero-extend both keys so the difference is a (KEYB+1)-bit two's-complement
  // value; taking its magnitude gives a distance with no wrap at the key ends.
  always_comb begin
    near_mask = '0;
    for (int i = 0; i < 5; i++) begin
      key_diff[i]  = {1'b0, zone_key_l_q[i]} - {1'b0, best_key};
      key_mag[i]   = key_diff[i][KEYB] ? (~key_diff[i] + 1'b1) : key_diff[i];
      near_mask[i] = zone_vld_l_q[i] && (key_mag[i] <= BsyHw);
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sort_bsy_d   = sort_bsy_q;
    bsy_ext_l_d  = bsy_ext_l_q;
    zone_vld_l_d = zone_vld_l_q;
    zone_key_l_d = zone_key_l_q;
    clct1_vld_d  = clct1_vld_q;
    clct1_pat_d  = clct1_pat_q;
    clct1_key_d  = clct1_key_q;
    clct1_sub_d  = clct1_sub_q;
    clct2_vld_d  = clct2_vld_q;
    clct2_pat_d  = clct2_pat_q;
    clct2_key_d  = clct2_key_q;
    clct2_sub_d  = clct2_sub_q;
    done_d       = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          bsy_ext_l_d  = bsy_ext;
          zone_vld_l_d = zone_vld;
          zone_key_l_d = zone_key_in;
          sort_bsy_d   = bsy_ext;
          clct1_vld_d  = 1'b0;
          clct2_vld_d  = 1'b0;
          cnt_d        = CntInit;
          state_d      = StPass1;
        end
      end
      StPass1: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          clct1_vld_d = cap_vld;
          clct1_pat_d = best_pat;
          clct1_key_d = best_key;
          clct1_sub_d = best_subkey;
          if (!cap_vld) begin
            // No first CLCT: a second pass cannot find anything either.
            clct2_vld_d = 1'b0;
            clct2_pat_d = '0;
            clct2_key_d = '0;
            clct2_sub_d = '0;
            done_d      = 1'b1;
            sort_bsy_d  = '0;
            state_d     = StIdle;
          end else begin
            sort_bsy_d = bsy_ext_l_q | near_mask;
            cnt_d      = CntInit;
            state_d    = StPass2;
          end
        end
      end
      StPass2: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          clct2_vld_d = cap_vld;
          clct2_pat_d = best_pat;
          clct2_key_d = best_key;
          clct2_sub_d = best_subkey;
          done_d      = 1'b1;
          sort_bsy_d  = '0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      sort_bsy_q   <= '0;
      bsy_ext_l_q  <= '0;
      zone_vld_l_q <= '0;
      zone_key_l_q <= '0;
      clct1_vld_q  <= 1'b0;
      clct1_pat_q  <= '0;
      clct1_key_q  <= '0;
      clct1_sub_q  <= '0;
      clct2_vld_q  <= 1'b0;
      clct2_pat_q  <= '0;
      clct2_key_q  <= '0;
      clct2_sub_q  <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sort_bsy_q   <= sort_bsy_d;
      bsy_ext_l_q  <= bsy_ext_l_d;
      zone_vld_l_q <= zone_vld_l_d;
      zone_key_l_q <= zone_key_l_d;
      clct1_vld_q  <= clct1_vld_d;
      clct1_pat_q  <= clct1_pat_d;
      clct1_key_q  <= clct1_key_d;
      clct1_sub_q  <= clct1_sub_d;
      clct2_vld_q  <= clct2_vld_d;
      clct2_pat_q  <= clct2_pat_d;
      clct2_key_q  <= clct2_key_d;
      clct2_sub_q  <= clct2_sub_d;
      done_q       <= done_d;
    end
  end

  assign sort_bsy     = sort_bsy_q;
  assign seq_busy     = (state_q != StIdle);
  assign clct1_vld    = clct1_vld_q;
  assign clct1_pat    = clct1_pat_q;
  assign clct1_key    = clct1_key_q;
  assign clct1_subkey = clct1_sub_q;
  assign clct2_vld    = clct2_vld_q;
  assign clct2_pat    = clct2_pat_q;
  assign clct2_key    = clct2_key_q;
  assign clct2_subkey = clct2_sub_q;
  assign done         = done_q;

endmodule

// File: tb/tb_pattern_busy_sequencer.sv
// Bench for pattern_busy_sequencer: a SORT_LAT=1 instance driven from a vector
// table, and a SORT_LAT=3 instance for latency / dropped-start sequences.
// A small behavioural best-of-5 sorter closes the loop on each instance.
module tb_pattern_busy_sequencer;

  typedef struct packed {
    logic [5:0] pat;
    logic [7:0] key;
    logic [9:0] sub;
    logic       bsy;
  } sort_t;

  typedef struct {
    logic [4:0]      bsy_ext;
    logic [4:0][5:0] pat;
    logic [4:0][7:0] key;
    logic [4:0][7:0] kout;
    logic            early;
    logic [4:0]      sb2;
    logic            c1v;
    logic [5:0]      c1p;
    logic [7:0]      c1k;
    logic [9:0]      c1s;
    logic            c2v;
    logic [5:0]      c2p;
    logic [7:0]      c2k;
    logic [9:0]      c2s;
  } vec_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic            reset_n, start1, start3;
  logic [4:0]      bsy_ext, zone_vld;
  logic [4:0][5:0] zpat;
  logic [4:0][7:0] zkey, zkout;
  sort_t           s1, s3;

  logic [4:0] sort_bsy1, sort_bsy3;
  logic       seq_busy1, seq_busy3, done1, done3;
  logic       c1v1, c2v1, c1v3, c2v3;
  logic [5:0] c1p1, c2p1, c1p3, c2p3;
  logic [7:0] c1k1, c2k1, c1k3, c2k3;
  logic [9:0] c1s1, c2s1, c1s3, c2s3;

  int errors = 0;
  int checks = 0;
  vec_t vecs [5];

  // Highest pattern among non-busy zones wins; subkey is the key with a fixed
  // 1/8-strip fraction so every field is distinct.
  function automatic sort_t sort_fn(input logic [4:0] sb, input logic [4:0][5:0] p,
                                    input logic [4:0][7:0] k);
    sort_t r;
    r     = '0;
    r.bsy = &sb;
    for (int i = 0; i < 5; i++) begin
      if (!sb[i] && p[i] > r.pat) begin
        r.pat = p[i];
        r.key = k[i];
        r.sub = {k[i], 2'b01};
      end
    end
    return r;
  endfunction

  assign s1 = sort_fn(sort_bsy1, zpat, zkout);
  assign s3 = sort_fn(sort_bsy3, zpat, zkout);

  pattern_busy_sequencer #(.SORT_LAT(1)) u_dut1 (
    .clock(clock), .reset_n(reset_n), .start(start1), .bsy_ext(bsy_ext), .zone_vld(zone_vld),
    .zone_key0(zkey[0]), .zone_key1(zkey[1]), .zone_key2(zkey[2]), .zone_key3(zkey[3]),
    .zone_key4(zkey[4]), .best_pat(s1.pat), .best_key(s1.key), .best_subkey(s1.sub),
    .best_bsy(s1.bsy), .sort_bsy(sort_bsy1), .seq_busy(seq_busy1),
    .clct1_vld(c1v1), .clct1_pat(c1p1), .clct1_key(c1k1), .clct1_subkey(c1s1),
    .clct2_vld(c2v1), .clct2_pat(c2p1), .clct2_key(c2k1), .clct2_subkey(c2s1), .done(done1)
  );

  pattern_busy_sequencer #(.SORT_LAT(3)) u_dut3 (
    .clock(clock), .reset_n(reset_n), .start(start3), .bsy_ext(bsy_ext), .zone_vld(zone_vld),
    .zone_key0(zkey[0]), .zone_key1(zkey[1]), .zone_key2(zkey[2]), .zone_key3(zkey[3]),
    .zone_key4(zkey[4]), .best_pat(s3.pat), .best_key(s3.key), .best_subkey(s3.sub),
    .best_bsy(s3.bsy), .sort_bsy(sort_bsy3), .seq_busy(seq_busy3),
    .clct1_vld(c1v3), .clct1_pat(c1p3), .clct1_key(c1k3), .clct1_subkey(c1s3),
    .clct2_vld(c2v3), .clct2_pat(c2p3), .clct2_key(c2k3), .clct2_subkey(c2s3), .done(done3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply(input int n);
    bsy_ext = vecs[n].bsy_ext;
    zpat    = vecs[n].pat;
    zkey    = vecs[n].key;
    zkout   = vecs[n].kout;
    for (int i = 0; i < 5; i++) zone_vld[i] = (vecs[n].pat[i] != 6'd0);
  endtask

  task automatic run_vec(input int n);
    vec_t v;
    v = vecs[n];
    @(negedge clock);
    apply(n);
    start1 = 1'b1;
    tick();  // E0
    start1 = 1'b0;
    chk($sformatf("v%0d e0 seq_busy", n), 32'(seq_busy1), 32'd1);
    chk($sformatf("v%0d e0 sort_bsy", n), 32'(sort_bsy1), 32'(v.bsy_ext));
    chk($sformatf("v%0d e0 clct1_vld", n), 32'(c1v1), 32'd0);
    chk($sformatf("v%0d e0 clct2_vld", n), 32'(c2v1), 32'd0);
    tick();  // E0+1
    chk($sformatf("v%0d clct1_vld", n), 32'(c1v1), 32'(v.c1v));
    chk($sformatf("v%0d clct1_pat", n), 32'(c1p1), 32'(v.c1p));
    chk($sformatf("v%0d clct1_key", n), 32'(c1k1), 32'(v.c1k));
    chk($sformatf("v%0d clct1_subkey", n), 32'(c1s1), 32'(v.c1s));
    if (!v.early) begin
      chk($sformatf("v%0d pass2 sort_bsy", n), 32'(sort_bsy1), 32'(v.sb2));
      chk($sformatf("v%0d pass2 done", n), 32'(done1), 32'd0);
      chk($sformatf("v%0d pass2 seq_busy", n), 32'(seq_busy1), 32'd1);
      tick();  // E0+2
    end
    chk($sformatf("v%0d clct2_vld", n), 32'(c2v1), 32'(v.c2v));
    chk($sformatf("v%0d clct2_pat", n), 32'(c2p1), 32'(v.c2p));
    chk($sformatf("v%0d clct2_key", n), 32'(c2k1), 32'(v.c2k));
    chk($sformatf("v%0d clct2_subkey", n), 32'(c2s1), 32'(v.c2s));
    chk($sformatf("v%0d done", n), 32'(done1), 32'd1);
    chk($sformatf("v%0d end seq_busy", n), 32'(seq_busy1), 32'd0);
    chk($sformatf("v%0d end sort_bsy", n), 32'(sort_bsy1), 32'd0);
    tick();
    chk($sformatf("v%0d done pulse", n), 32'(done1), 32'd0);
  endtask

  initial begin
    // Best at zone 2 (key 90 corrected to 91), then zone 4 key 170.
    vecs[0] = '{bsy_ext: 5'b00000,
                pat: {6'd30, 6'd7, 6'd40, 6'd6, 6'd5},
                key: {8'd170, 8'd130, 8'd90, 8'd50, 8'd20},
                kout: {8'd170, 8'd130, 8'd91, 8'd50, 8'd20},
                early: 1'b0, sb2: 5'b00100,
                c1v: 1'b1, c1p: 6'd40, c1k: 8'd91, c1s: 10'd365,
                c2v: 1'b1, c2p: 6'd30, c2k: 8'd170, c2s: 10'd681};
    // Best key 44: zones 0,1 near, zone 2 at distance 16 stays available.
    vecs[1] = '{bsy_ext: 5'b00000,
                pat: {6'd12, 6'd30, 6'd20, 6'd50, 6'd10},
                key: {8'd140, 8'd100, 8'd60, 8'd45, 8'd40},
                kout: {8'd140, 8'd100, 8'd60, 8'd44, 8'd40},
                early: 1'b0, sb2: 5'b00011,
                c1v: 1'b1, c1p: 6'd50, c1k: 8'd44, c1s: 10'd177,
                c2v: 1'b1, c2p: 6'd30, c2k: 8'd100, c2s: 10'd401};
    // All patterns zero: early exit.
    vecs[2] = '{bsy_ext: 5'b00000,
                pat: {6'd0, 6'd0, 6'd0, 6'd0, 6'd0},
                key: {8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
                kout: {8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
                early: 1'b1, sb2: 5'b00000,
                c1v: 1'b0, c1p: 6'd0, c1k: 8'd0, c1s: 10'd0,
                c2v: 1'b0, c2p: 6'd0, c2k: 8'd0, c2s: 10'd0};
    // Forced busy 11011, single valid zone 2: pass 2 sees all zones busy.
    vecs[3] = '{bsy_ext: 5'b11011,
                pat: {6'd0, 6'd0, 6'd33, 6'd0, 6'd0},
                key: {8'd200, 8'd150, 8'd77, 8'd10, 8'd5},
                kout: {8'd200, 8'd150, 8'd79, 8'd10, 8'd5},
                early: 1'b0, sb2: 5'b11111,
                c1v: 1'b1, c1p: 6'd33, c1k: 8'd79, c1s: 10'd317,
                c2v: 1'b0, c2p: 6'd0, c2k: 8'd0, c2s: 10'd0};
    // Key 0 winner: distance 7 masked, 8 not, key 255 not (no wrap).
    vecs[4] = '{bsy_ext: 5'b00100,
                pat: {6'd25, 6'd20, 6'd63, 6'd5, 6'd60},
                key: {8'd128, 8'd7, 8'd255, 8'd8, 8'd0},
                kout: {8'd128, 8'd7, 8'd255, 8'd8, 8'd0},
                early: 1'b0, sb2: 5'b01101,
                c1v: 1'b1, c1p: 6'd60, c1k: 8'd0, c1s: 10'd1,
                c2v: 1'b1, c2p: 6'd25, c2k: 8'd128, c2s: 10'd513};

    reset_n  = 1'b1;
    start1   = 1'b0;
    start3   = 1'b0;
    bsy_ext  = '0;
    zone_vld = '0;
    zpat     = '0;
    zkey     = '0;
    zkout    = '0;
    #2 reset_n = 1'b0;
    tick();
    tick();
    chk("reset sort_bsy", 32'(sort_bsy1), 32'd0);
    chk("reset seq_busy", 32'(seq_busy1), 32'd0);
    chk("reset done", 32'(done1), 32'd0);
    chk("reset clct1_vld", 32'(c1v1), 32'd0);
    chk("reset clct2_vld", 32'(c2v1), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    for (int n = 0; n < 5; n++) run_vec(n);

    // SORT_LAT=3: latency, dropped start at E0+2, next start at E0+7.
    @(negedge clock);
    apply(0);
    start3 = 1'b1;
    tick();  // E0
    start3 = 1'b0;
    chk("l3 e0 seq_busy", 32'(seq_busy3), 32'd1);
    tick();  // E0+1
    @(negedge clock);
    start3 = 1'b1;
    tick();  // E0+2, dropped
    start3 = 1'b0;
    chk("l3 e2 clct1_vld", 32'(c1v3), 32'd0);
    chk("l3 e2 sort_bsy", 32'(sort_bsy3), 32'd0);
    tick();  // E0+3
    chk("l3 e3 clct1_vld", 32'(c1v3), 32'd1);
    chk("l3 e3 clct1_key", 32'(c1k3), 32'd91);
    chk("l3 e3 sort_bsy", 32'(sort_bsy3), 32'b00100);
    tick();
    tick();  // E0+5
    chk("l3 e5 done", 32'(done3), 32'd0);
    chk("l3 e5 seq_busy", 32'(seq_busy3), 32'd1);
    tick();  // E0+6
    chk("l3 e6 done", 32'(done3), 32'd1);
    chk("l3 e6 clct2_key", 32'(c2k3), 32'd170);
    chk("l3 e6 clct2_vld", 32'(c2v3), 32'd1);
    chk("l3 e6 seq_busy", 32'(seq_busy3), 32'd0);
    chk("l3 e6 sort_bsy", 32'(sort_bsy3), 32'd0);
    @(negedge clock);
    start3 = 1'b1;
    tick();  // E0+7, accepted
    start3 = 1'b0;
    chk("l3 e7 seq_busy", 32'(seq_busy3), 32'd1);
    chk("l3 e7 clct1_vld", 32'(c1v3), 32'd0);
    chk("l3 e7 clct2_vld", 32'(c2v3), 32'd0);
    chk("l3 e7 done", 32'(done3), 32'd0);
    for (int i = 0; i < 6; i++) tick();
    chk("l3 rerun done", 32'(done3), 32'd1);
    chk("l3 rerun clct1_key", 32'(c1k3), 32'd91);

    // Mid-pass asynchronous reset on both instances.
    @(negedge clock);
    apply(0);
    start1 = 1'b1;
    start3 = 1'b1;
    tick();  // E0
    start1 = 1'b0;
    start3 = 1'b0;
    tick();  // E0+1
    reset_n = 1'b0;
    #1;
    chk("rst clct1_vld", 32'(c1v1), 32'd0);
    chk("rst clct1_key", 32'(c1k1), 32'd0);
    chk("rst clct2_key", 32'(c2k1), 32'd0);
    chk("rst clct2_subkey", 32'(c2s1), 32'd0);
    chk("rst sort_bsy", 32'(sort_bsy1), 32'd0);
    chk("rst seq_busy", 32'(seq_busy1), 32'd0);
    chk("rst l3 seq_busy", 32'(seq_busy3), 32'd0);
    chk("rst l3 clct2_key", 32'(c2k3), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("rst no done %0d", i), 32'({done1, done3}), 32'd0);
    end
    @(negedge clock);
    reset_n = 1'b1;
    run_vec(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pattern_busy_sequencer.md
# pattern_busy_sequencer

Two-pass scheduler for the combinational best-1-of-5 zone sorter in the ccLUT pattern finder. It drives the sorter's five per-zone busy inputs. Pass 1 captures the first CLCT. Pass 2 marks busy every zone whose candidate key lies near the first CLCT's key, then captures the second CLCT from the same sorter. The block sits between the zone pattern finders and the CLCT output register stage, once per bunch crossing.

## Interface
Parameters:
- PATB, 6, width of pattern/sort quantity (sorter best_pat)
- KEYB, 8, width of full 1/2-strip key (sorter best_key)
- SUBKEYB, 10, width of 1/8-strip subkey (sorter best_subkey)
- SORT_LAT, 1, edges from a sort_bsy change to a stable sorter result; legal range 1..7
- BSY_HW, 7, busy half-width in key units; must be >= 2

Ports (clock and reset first):
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to run both passes; ignored unless idle
- bsy_ext  in  5  externally forced zone busy mask, sampled at start
- zone_vld  in  5  per-zone candidate present (pattern nonzero), sampled at start
- zone_key0..zone_key4  in  KEYB each  per-zone candidate full key, sampled at start
- best_pat  in  PATB  sorter result pattern
- best_key  in  KEYB  sorter result key
- best_subkey  in  SUBKEYB  sorter result subkey
- best_bsy  in  1  sorter reports all zones busy
- sort_bsy  out  5  registered busy mask to sorter bsy0..bsy4 (bit i = zone i)
- seq_busy  out  1  sequencer not idle
- clct1_vld, clct1_pat, clct1_key, clct1_subkey  out  1/PATB/KEYB/SUBKEYB  first CLCT
- clct2_vld, clct2_pat, clct2_key, clct2_subkey  out  same  second CLCT
- done  out  1  one-cycle pulse; clct1/clct2 outputs are final

## Operation
- States: IDLE, PASS1, PASS2. A wait counter of 3 bits counts SORT_LAT edges.
- IDLE, start=1 at edge E0:
  - Latch bsy_ext, zone_vld and zone_key*.
  - sort_bsy <= bsy_ext. Clear both clct vld. Counter <= SORT_LAT-1. Go to PASS1.
- PASS1: decrement counter. At the edge where the counter is 0, capture the sorter into clct1_*:
  - clct1_vld = (best_pat != 0) && !best_bsy.
  - If clct1_vld=0: clct2_* <= 0, done pulses, go to IDLE.
  - Else: sort_bsy <= bsy_ext_l | near_mask, counter <= SORT_LAT-1, go to PASS2.
- near_mask rule: bit i = zone_vld_l[i] && |zone_key_l[i] - best_key| <= BSY_HW.
  - Computed as an unsigned magnitude of a (KEYB+1)-bit signed difference; no wrap-around between key 0 and the maximum key.
  - Because the sorter's offset correction moves the key by at most ±2 and BSY_HW >= 2, the winning zone is always included.
- PASS2: at the edge where the counter is 0, capture the sorter into clct2_* with the same vld rule, pulse done, go to IDLE.
- Entering IDLE after a run: sort_bsy <= 0.
- clct outputs hold their values until the next accepted start clears the vld bits. pat/key/subkey also hold.
- start while seq_busy=1 is dropped. It is not queued.
- Asynchronous reset (reset_n=0), at any state including mid-pass:
  - State IDLE, counter 0, sort_bsy 0, seq_busy 0, done 0.
  - All clct1_* and clct2_* fields 0.
  - Latched inputs 0.
  - A pass in progress is abandoned and no done is issued.

## Timing
- Latency with start sampled at edge E0 and L = SORT_LAT:
  - clct1 loads at E0+L.
  - clct2 and done load at E0+2L, so done is high during the cycle after E0+2L.
  - Early exit (no first CLCT): done loads at E0+L.
- seq_busy is high from E0 until the edge that loads done. The next start is accepted at the edge after done (earliest E0+2L+1).
- sort_bsy only changes at E0, at the clct1 capture edge, and at return to IDLE.
- Upstream must hold the sorter inputs stable from E0 through the final capture edge.

## Test plan
- L=1, zone_vld=5'b11111, keys 20/50/90/130/170, best at zone 2 key 91:
  - sort_bsy=5'b00100 after E0+1.
  - Sorter then yields zone 4 key 170.
  - clct1_key=91, clct2_key=170, done high after E0+2.
- Near-mask spread: keys 40/45/60/100/140, best key 44, BSY_HW=7 -> sort_bsy=5'b00011, zone 2 (distance 16) stays unmasked.
- All patterns zero -> clct1_vld=0, clct2_vld=0, done after E0+1, sort_bsy returns to 0.
- bsy_ext=5'b11011 with a single valid zone 2:
  - clct1 comes from zone 2.
  - Pass-2 sorter reports best_bsy=1, so clct2_vld=0 and sort_bsy=5'b11111 during PASS2.
- L=3: start at E0 -> clct1 at E0+3, done after E0+6. A second start at E0+2 is ignored, and the next start at E0+7 is accepted.
- reset_n low at E0+1 during PASS1 -> all outputs 0 immediately, no done. A start after reset release runs normally.
